regfile_dumper: RTL

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_dumper.sv
// rtl/regfile_dumper.sv - walks a register-file window and streams each register out as one beat
module regfile_dumper #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  RdAddr,
    input  logic [31:0] ReadData,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_reg,
    output logic [31:0] dump_data,
    output logic [5:0]  dump_count,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    logic [4:0] ptr;
    logic       accept;

    assign RdAddr = ptr;
    assign accept = dump_valid && dump_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= 5'd0;
            dump_reg   <= 5'd0;
            dump_data  <= 32'd0;
            dump_count <= 6'd0;
            dump_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ptr        <= FIRST;
                        dump_count <= 6'd0;
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        dump_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        dump_data  <= ReadData;
                        dump_reg   <= ptr;
                        dump_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    // a beat accepted in the same cycle as abort still counts
                    if (accept) begin
                        dump_count <= dump_count + 6'd1;
                        dump_valid <= 1'b0;
                    end
                    if (abort) begin
                        dump_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (accept) begin
                        if (ptr == LAST) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            ptr   <= ptr + 5'd1;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
